// File: rtl/ball_motion_fp.sv
// ball_motion_fp
// ---------------------------------------------------------------------------
// Fixed-point motion engine for one table ball. Once per frame the position
// is advanced by the signed velocity and friction pulls the speed towards
// zero without crossing it. On the following cycle the ball is clamped into
// the play area and reflected off any border it is moving out through.
// A contact with another ball delivers one velocity impulse per contact, and
// a load request teleports the ball to a new resting position.
//
// Ports
//   clk              system clock
//   reset            synchronous, active-high reset
//   startOfFrame     one-cycle pulse per frame (starts the S0 integrate step)
//   impulse_valid    level, contact with another ball is present
//   impulse_x_speed  signed X speed to adopt on contact
//   impulse_y_speed  signed Y speed to adopt on contact
//   load             one-cycle teleport request
//   load_x, load_y   signed new top-left position, pixels
//   topLeftX/Y       signed top-left position, pixels (floor of fixed point)
//   x_speed/y_speed  signed current speed, sub-pixels per frame
//   stopped          high while the ball is at rest
//   stop_pulse       one-cycle pulse when the ball comes to rest
// ---------------------------------------------------------------------------
module ball_motion_fp #(
    parameter int INITIAL_X       = 280,
    parameter int INITIAL_Y       = 185,
    parameter int INITIAL_X_SPEED = 0,
    parameter int INITIAL_Y_SPEED = 0,
    parameter int FRAC_BITS       = 7,
    parameter int POS_W           = 11,
    parameter int SPEED_W         = 11,
    parameter int FRICTION        = 2,
    parameter int MAX_SPEED       = 230,
    parameter int X_MIN           = 30,
    parameter int X_MAX           = 609,
    parameter int Y_MIN           = 30,
    parameter int Y_MAX           = 449,
    parameter int OBJ_W           = 32,
    parameter int OBJ_H           = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic                      impulse_valid,
    input  logic signed [SPEED_W-1:0] impulse_x_speed,
    input  logic signed [SPEED_W-1:0] impulse_y_speed,
    input  logic                      load,
    input  logic signed [POS_W-1:0]   load_x,
    input  logic signed [POS_W-1:0]   load_y,
    output logic signed [POS_W-1:0]   topLeftX,
    output logic signed [POS_W-1:0]   topLeftY,
    output logic signed [SPEED_W-1:0] x_speed,
    output logic signed [SPEED_W-1:0] y_speed,
    output logic                      stopped,
    output logic                      stop_pulse
);

    // Internal position: one guard bit above the pixel range so that the
    // integrate step can overshoot a border without wrapping before BOUND.
    localparam int PW   = POS_W + FRAC_BITS + 1;
    localparam int UNIT = 1 << FRAC_BITS;

    localparam logic signed [PW-1:0] X_LO   = PW'(X_MIN * UNIT);
    localparam logic signed [PW-1:0] X_HI   = PW'((X_MAX - OBJ_W + 1) * UNIT);
    localparam logic signed [PW-1:0] Y_LO   = PW'(Y_MIN * UNIT);
    localparam logic signed [PW-1:0] Y_HI   = PW'((Y_MAX - OBJ_H + 1) * UNIT);
    localparam logic signed [PW-1:0] X_INIT = PW'(INITIAL_X * UNIT);
    localparam logic signed [PW-1:0] Y_INIT = PW'(INITIAL_Y * UNIT);

    localparam logic signed [SPEED_W-1:0] VX_INIT = SPEED_W'(INITIAL_X_SPEED);
    localparam logic signed [SPEED_W-1:0] VY_INIT = SPEED_W'(INITIAL_Y_SPEED);

    // Two extra bits so that negating the most negative speed cannot wrap.
    localparam logic signed [SPEED_W+1:0] SAT_HI = (SPEED_W+2)'(MAX_SPEED);
    localparam logic signed [SPEED_W+1:0] SAT_LO = -SAT_HI;

    localparam logic signed [SPEED_W-1:0] FR_POS = SPEED_W'(FRICTION);
    localparam logic signed [SPEED_W-1:0] FR_NEG = -FR_POS;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_MOVING  = 1'b1
    } state_t;

    localparam state_t ST_INIT =
        (INITIAL_X_SPEED == 0 && INITIAL_Y_SPEED == 0) ? ST_STOPPED : ST_MOVING;

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------
    function automatic logic signed [SPEED_W+1:0] widen(input logic signed [SPEED_W-1:0] v);
        return {{2{v[SPEED_W-1]}}, v};
    endfunction

    function automatic logic signed [SPEED_W-1:0] sat_speed(input logic signed [SPEED_W+1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[SPEED_W-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[SPEED_W-1:0];
        end else begin
            return v[SPEED_W-1:0];
        end
    endfunction

    function automatic logic signed [SPEED_W-1:0] neg_sat(input logic signed [SPEED_W-1:0] v);
        return sat_speed(-widen(v));
    endfunction

    // Friction never carries the speed across zero: anything within one
    // friction step of zero lands exactly on zero.
    function automatic logic signed [SPEED_W-1:0] apply_friction(input logic signed [SPEED_W-1:0] v);
        if (v > FR_POS) begin
            return v - FR_POS;
        end else if (v < FR_NEG) begin
            return v - FR_NEG;
        end else begin
            return '0;
        end
    endfunction

    function automatic logic signed [PW-1:0] speed_to_pos(input logic signed [SPEED_W-1:0] v);
        return {{(PW-SPEED_W){v[SPEED_W-1]}}, v};
    endfunction

    function automatic logic signed [PW-1:0] px_to_pos(input logic signed [POS_W-1:0] p);
        return {p[POS_W-1], p, {FRAC_BITS{1'b0}}};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [PW-1:0]      pos_x, pos_y;
    logic signed [SPEED_W-1:0] vel_x, vel_y;
    logic                      vld_p1;      // BOUND step pending this cycle
    logic                      armed;
    state_t                    state, state_nxt;

    logic signed [PW-1:0]      pos_x_p0, pos_y_p0, pos_x_nxt, pos_y_nxt;
    logic signed [SPEED_W-1:0] vel_x_p0, vel_y_p0, vel_x_nxt, vel_y_nxt;
    logic                      vld_nxt;

    logic                      accept;
    logic signed [SPEED_W-1:0] imp_x_sat, imp_y_sat;
    logic                      imp_nonzero;

    assign accept      = impulse_valid & armed;
    assign imp_x_sat   = sat_speed(widen(impulse_x_speed));
    assign imp_y_sat   = sat_speed(widen(impulse_y_speed));
    assign imp_nonzero = accept & ~load & ((imp_x_sat != '0) | (imp_y_sat != '0));

    // ------------------------------------------------------------------
    // Datapath: BOUND (stage 1) is resolved first, so that a frame start
    // landing in the BOUND cycle integrates from the clamped values.
    // ------------------------------------------------------------------
    always_comb begin
        pos_x_p0 = pos_x;
        pos_y_p0 = pos_y;
        vel_x_p0 = vel_x;
        vel_y_p0 = vel_y;

        if (vld_p1) begin
            if (pos_x < X_LO) begin
                pos_x_p0 = X_LO;
                if (vel_x[SPEED_W-1]) vel_x_p0 = neg_sat(vel_x);
            end else if (pos_x > X_HI) begin
                pos_x_p0 = X_HI;
                if (!vel_x[SPEED_W-1] && vel_x != '0) vel_x_p0 = neg_sat(vel_x);
            end

            if (pos_y < Y_LO) begin
                pos_y_p0 = Y_LO;
                if (vel_y[SPEED_W-1]) vel_y_p0 = neg_sat(vel_y);
            end else if (pos_y > Y_HI) begin
                pos_y_p0 = Y_HI;
                if (!vel_y[SPEED_W-1] && vel_y != '0) vel_y_p0 = neg_sat(vel_y);
            end
        end

        // ---- stage 0: integrate and apply friction ----
        pos_x_nxt = pos_x_p0;
        pos_y_nxt = pos_y_p0;
        vel_x_nxt = vel_x_p0;
        vel_y_nxt = vel_y_p0;
        vld_nxt   = startOfFrame;

        if (startOfFrame) begin
            pos_x_nxt = pos_x_p0 + speed_to_pos(vel_x_p0);
            pos_y_nxt = pos_y_p0 + speed_to_pos(vel_y_p0);
            vel_x_nxt = apply_friction(vel_x_p0);
            vel_y_nxt = apply_friction(vel_y_p0);
        end

        // An impulse replaces whatever speed reflection or friction produced.
        if (accept) begin
            vel_x_nxt = imp_x_sat;
            vel_y_nxt = imp_y_sat;
        end

        if (load) begin
            pos_x_nxt = px_to_pos(load_x);
            pos_y_nxt = px_to_pos(load_y);
            vel_x_nxt = '0;
            vel_y_nxt = '0;
            vld_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x  <= X_INIT;
            pos_y  <= Y_INIT;
            vel_x  <= VX_INIT;
            vel_y  <= VY_INIT;
            vld_p1 <= 1'b0;
            armed  <= 1'b1;
        end else begin
            pos_x  <= pos_x_nxt;
            pos_y  <= pos_y_nxt;
            vel_x  <= vel_x_nxt;
            vel_y  <= vel_y_nxt;
            vld_p1 <= vld_nxt;
            // Re-arm only once the contact has ended, so a held contact
            // delivers a single impulse.
            if (accept) begin
                armed <= 1'b0;
            end else if (!impulse_valid) begin
                armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Motion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_INIT;
            stop_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            stop_pulse <= (state == ST_MOVING) && (state_nxt == ST_STOPPED);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOPPED: begin
                if (imp_nonzero) state_nxt = ST_MOVING;
            end
            ST_MOVING: begin
                // A fresh impulse arriving as the speeds hit zero keeps the
                // ball moving rather than reporting a stop.
                if (vel_x == '0 && vel_y == '0 && !imp_nonzero) state_nxt = ST_STOPPED;
            end
            default: state_nxt = ST_STOPPED;
        endcase
    end

    always_comb begin
        stopped = (state == ST_STOPPED);
    end

    assign topLeftX = pos_x[POS_W+FRAC_BITS-1:FRAC_BITS];
    assign topLeftY = pos_y[POS_W+FRAC_BITS-1:FRAC_BITS];
    assign x_speed  = vel_x;
    assign y_speed  = vel_y;

endmodule

// File: tb/tb_ball_motion_fp.sv
// Directed testbench for ball_motion_fp with default parameters
// (F=7, MAX_SPEED=230, FRICTION=2, X range 30..578, Y range 30..418).
module tb_ball_motion_fp;

    localparam int POS_W   = 11;
    localparam int SPEED_W = 11;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      startOfFrame;
    logic                      impulse_valid;
    logic signed [SPEED_W-1:0] impulse_x_speed;
    logic signed [SPEED_W-1:0] impulse_y_speed;
    logic                      load;
    logic signed [POS_W-1:0]   load_x;
    logic signed [POS_W-1:0]   load_y;
    logic signed [POS_W-1:0]   topLeftX;
    logic signed [POS_W-1:0]   topLeftY;
    logic signed [SPEED_W-1:0] x_speed;
    logic signed [SPEED_W-1:0] y_speed;
    logic                      stopped;
    logic                      stop_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    ball_motion_fp dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .impulse_valid   (impulse_valid),
        .impulse_x_speed (impulse_x_speed),
        .impulse_y_speed (impulse_y_speed),
        .load            (load),
        .load_x          (load_x),
        .load_y          (load_y),
        .topLeftX        (topLeftX),
        .topLeftY        (topLeftY),
        .x_speed         (x_speed),
        .y_speed         (y_speed),
        .stopped         (stopped),
        .stop_pulse      (stop_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic impulse(input int vx, input int vy);
        impulse_valid   = 1'b1;
        impulse_x_speed = SPEED_W'(vx);
        impulse_y_speed = SPEED_W'(vy);
        tick();
        impulse_valid   = 1'b0;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; impulse_valid = 1'b0;
        impulse_x_speed = '0; impulse_y_speed = '0;
        load = 1'b0; load_x = '0; load_y = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_x", topLeftX, 280);
        chk("rst_y", topLeftY, 185);
        chk("rst_vx", x_speed, 0);
        chk("rst_vy", y_speed, 0);
        chk("rst_stopped", stopped, 1);
        chk("rst_pulse", stop_pulse, 0);

        // Impulse (5,0), then friction 5->3->1->0
        impulse(5, 0);
        chk("imp5_vx", x_speed, 5);
        chk("imp5_moving", stopped, 0);
        frame();
        chk("f1_vx", x_speed, 3);
        tick();
        chk("f1_x", topLeftX, 280);
        frame();
        chk("f2_vx", x_speed, 1);
        tick();
        frame();
        chk("f3_vx", x_speed, 0);
        chk("f3_stopped", stopped, 0);
        chk("f3_pulse", stop_pulse, 0);
        tick();
        chk("stop_stopped", stopped, 1);
        chk("stop_pulse", stop_pulse, 1);
        chk("stop_vx", x_speed, 0);
        tick();
        chk("stop_pulse_end", stop_pulse, 0);
        chk("stop_x", topLeftX, 280);

        // Held contact: only the first impulse is taken
        impulse_valid   = 1'b1;
        impulse_x_speed = 11'sd100;
        impulse_y_speed = -11'sd40;
        repeat (5) tick();
        impulse_x_speed = 11'sd7;
        impulse_y_speed = 11'sd7;
        repeat (5) tick();
        chk("hold_vx", x_speed, 100);
        chk("hold_vy", y_speed, -40);
        impulse_valid = 1'b0;
        tick();
        impulse(7, 7);
        chk("rearm_vx", x_speed, 7);
        chk("rearm_vy", y_speed, 7);

        // Load to x=600 while moving
        load = 1'b1; load_x = 11'sd600; load_y = 11'sd200;
        tick();
        load = 1'b0;
        chk("ld600_x", topLeftX, 600);
        chk("ld600_y", topLeftY, 200);
        chk("ld600_vx", x_speed, 0);
        tick();
        chk("ld600_stopped", stopped, 1);
        chk("ld600_pulse", stop_pulse, 1);

        // Right border: 76800+230 -> 601 px, then clamp to 578 and reflect
        impulse(230, 0);
        chk("r_vx", x_speed, 230);
        frame();
        chk("r_s0_x", topLeftX, 601);
        chk("r_s0_vx", x_speed, 228);
        tick();
        chk("r_bnd_x", topLeftX, 578);
        chk("r_bnd_vx", x_speed, -228);
        frame();
        chk("r_f2_x", topLeftX, 576);
        chk("r_f2_vx", x_speed, -226);
        tick();

        // Saturation of impulse values
        impulse(300, -300);
        chk("sat_vx", x_speed, 230);
        chk("sat_vy", y_speed, -230);
        tick();

        // Load + frame start + impulse in the same cycle: load wins
        impulse_valid = 1'b1; impulse_x_speed = 11'sd50; impulse_y_speed = 11'sd50;
        load = 1'b1; load_x = 11'sd100; load_y = 11'sd200;
        startOfFrame = 1'b1;
        tick();
        impulse_valid = 1'b0; load = 1'b0; startOfFrame = 1'b0;
        chk("lsi_x", topLeftX, 100);
        chk("lsi_y", topLeftY, 200);
        chk("lsi_vx", x_speed, 0);
        chk("lsi_vy", y_speed, 0);
        chk("lsi_pulse0", stop_pulse, 0);
        tick();
        chk("lsi_stopped", stopped, 1);
        chk("lsi_pulse1", stop_pulse, 1);
        tick();
        chk("lsi_pulse2", stop_pulse, 0);

        // Load outside the play area together with a frame start: no clamp follows
        load = 1'b1; load_x = 11'sd10; load_y = 11'sd200; startOfFrame = 1'b1;
        tick();
        load = 1'b0; startOfFrame = 1'b0;
        chk("cancel_x0", topLeftX, 10);
        tick();
        chk("cancel_x1", topLeftX, 10);

        // Left border with a frame start in the BOUND cycle:
        // 1280-20=1260 (9 px, v=-18); then clamp 3840, v=+18, integrate 3858, v=16
        impulse(-20, 0);
        chk("l_vx", x_speed, -20);
        startOfFrame = 1'b1;
        tick();
        chk("l_s0_x", topLeftX, 9);
        chk("l_s0_vx", x_speed, -18);
        tick();
        startOfFrame = 1'b0;
        chk("l_b2b_x", topLeftX, 30);
        chk("l_b2b_vx", x_speed, 16);
        tick();
        chk("l_bnd_x", topLeftX, 30);
        chk("l_bnd_vx", x_speed, 16);

        // Bottom border on Y: 56320+10 -> 440 px, clamp to 418, vy -8
        load = 1'b1; load_x = 11'sd100; load_y = 11'sd440;
        tick();
        load = 1'b0;
        chk("yl_y", topLeftY, 440);
        impulse(0, 10);
        chk("y_vy", y_speed, 10);
        frame();
        chk("y_s0_y", topLeftY, 440);
        chk("y_s0_vy", y_speed, 8);
        tick();
        chk("y_bnd_y", topLeftY, 418);
        chk("y_bnd_vy", y_speed, -8);
        chk("y_bnd_x", topLeftX, 100);
        chk("y_bnd_vx", x_speed, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
